// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and default parameters for the SPI master core
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    localparam int          DEFAULT_DATA_WIDTH = 8;
    localparam int          DEFAULT_CLK_DIV    = 1;
    localparam logic [31:0] DEFAULT_INIT_DATA  = 32'h0000_00A5;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - sclk divider producing rise/fall toggle strobes while enabled
module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    // Strobes flag the edge on which sclk will toggle, so the core can act on the same edge.
    assign wrap = en && (cnt == LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - mode-0 SPI master transmitting an incrementing word; SPI_MASTER_LSB_FIRST_EN selects LSB-first
module spi_master_core
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    CLK_DIV    = DEFAULT_CLK_DIV,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = DEFAULT_INIT_DATA[DATA_WIDTH-1:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    output logic master_out,
    output logic sclk,
    output logic done
);

    localparam int            BW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

    spi_state_e            state;
    spi_state_e            next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [BW-1:0]         bit_cnt;
    logic                  div_en;
    logic                  rise;
    logic                  fall;
    logic                  last_fall;
    logic                  tx_bit;

    assign div_en    = (state == ST_SHIFT) && !ss;
    assign last_fall = fall && (bit_cnt == LAST_BIT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!ss) next_state = ST_LOAD;
            ST_LOAD:  next_state = ss ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: begin
                if (ss) begin
                    next_state = ST_IDLE;
                end else if (last_fall) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ss ? ST_IDLE : ST_LOAD;
            default:  next_state = ST_IDLE;
        endcase
    end

    // An abort leaves tx_word alone, so the interrupted word is resent on the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            tx_word <= INIT_DATA;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    shreg   <= tx_word;
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (!ss) begin
                        if (rise) begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                        if (fall && !last_fall) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                            shreg <= shreg >> 1;
`else
                            shreg <= shreg << 1;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    tx_word <= tx_word + DATA_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_bit = shreg[0];
`else
    assign tx_bit = shreg[DATA_WIDTH-1];
`endif

    // Outputs decode straight from state so reset clears them without waiting for an edge.
    assign master_out = (state == ST_SHIFT) && tx_bit;
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - self-checking bench for spi_master_core (default and CLK_DIV=3/INIT=FF instances)
module tb_spi_master_core;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic ss_a = 1'b1;
    logic ss_b = 1'b1;
    logic mo_a, sclk_a, done_a;
    logic mo_b, sclk_b, done_b;

    bit   sel = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    logic [7:0] model_word [2];

    always #5 clk = ~clk;

    spi_master_core u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss_a),
        .master_out (mo_a),
        .sclk       (sclk_a),
        .done       (done_a)
    );

    spi_master_core #(
        .DATA_WIDTH (8),
        .CLK_DIV    (3),
        .INIT_DATA  (8'hFF)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss_b),
        .master_out (mo_b),
        .sclk       (sclk_b),
        .done       (done_b)
    );

    function automatic logic [2:0] obs();
        return sel ? {done_b, sclk_b, mo_b} : {done_a, sclk_a, mo_a};
    endfunction

    function automatic int cur_div();
        return sel ? 3 : 1;
    endfunction

    function automatic logic [7:0] init_word();
        return sel ? 8'hFF : 8'hA5;
    endfunction

    // Bit k of the serial stream for word w.
    function automatic logic stream_bit(input logic [7:0] w, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    task automatic set_ss(input logic v);
        if (sel) ss_b = v;
        else     ss_a = v;
    endtask

    task automatic check(input string tag, input logic [2:0] o, input logic [2:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed {done,sclk,mosi}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic shift_cycle(input logic [7:0] w, input int i);
        int div;
        logic [2:0] e;
        div = cur_div();
        e = {1'b0, ((i / div) % 2) == 1, stream_bit(w, i / (2 * div))};
        @(negedge clk);
        check($sformatf("shift w=%h cyc=%0d dut=%0d", w, i, sel), obs(), e);
    endtask

    // Precondition: ss low, DUT enters LOAD on the next edge.
    task automatic full_frame();
        logic [7:0] w;
        w = model_word[sel];
        @(negedge clk);
        check($sformatf("load w=%h dut=%0d", w, sel), obs(), 3'b000);
        for (int i = 0; i < 2 * cur_div() * 8; i++) shift_cycle(w, i);
        @(negedge clk);
        check($sformatf("done w=%h dut=%0d", w, sel), obs(), 3'b100);
        model_word[sel] = w + 8'd1;
    endtask

    task automatic aborted_frame(input int k);
        logic [7:0] w;
        w = model_word[sel];
        @(negedge clk);
        check($sformatf("abort load w=%h", w), obs(), 3'b000);
        for (int i = 0; i < k; i++) shift_cycle(w, i);
        set_ss(1'b1);
        @(negedge clk);
        check($sformatf("abort idle k=%0d", k), obs(), 3'b000);
        @(negedge clk);
        check($sformatf("abort no done k=%0d", k), obs(), 3'b000);
    endtask

    task automatic idle_gap(input int n);
        set_ss(1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle gap %0d dut=%0d", i, sel), obs(), 3'b000);
        end
    endtask

    initial begin
        model_word[0] = 8'hA5;
        model_word[1] = 8'hFF;

        repeat (2) @(negedge clk);
        sel = 1'b0;
        check("reset a", obs(), 3'b000);
        sel = 1'b1;
        check("reset b", obs(), 3'b000);

        // Back-to-back frames from reset release with ss already low.
        sel = 1'b0;
        set_ss(1'b0);
        @(negedge clk);
        rst = 1'b1;
        full_frame();
        full_frame();
        idle_gap(2);
        set_ss(1'b0);
        aborted_frame(6);
        set_ss(1'b0);
        full_frame();

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                aborted_frame($urandom_range(0, 15));
                idle_gap($urandom_range(0, 2));
            end else begin
                full_frame();
                if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
            end
            set_ss(1'b0);
        end

        // Reset in the middle of SHIFT while sclk is high.
        @(negedge clk);
        check("pre-reset load", obs(), 3'b000);
        for (int i = 0; i < 4; i++) shift_cycle(model_word[0], i);
        #2 rst = 1'b0;
        #1 check("async reset outputs", obs(), 3'b000);
        model_word[0] = 8'hA5;
        model_word[1] = 8'hFF;
        @(negedge clk);
        rst = 1'b1;
        full_frame();
        idle_gap(1);

        // Divided clock and word wrap on the second instance.
        sel = 1'b1;
        set_ss(1'b0);
        full_frame();
        full_frame();
        aborted_frame($urandom_range(0, 47));
        set_ss(1'b0);
        full_frame();
        idle_gap(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
